// File: rtl/time_set_ctrl.sv
// Clock time-setting controller: 1 Hz seconds carry, button-driven set mode, preset bus and PE.
// Latency: state, PE, mode, blink, cin_sec and pre_* are registered one cycle after the causing edge; buttons are edge-only.
module time_set_ctrl #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       _CR,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic       cin_sec,
  output logic [7:0] pre_hour,
  output logic [7:0] pre_min,
  output logic [7:0] pre_sec,
  output logic       PE,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int DW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;

  state_t          state, state_nxt;
  logic            prev_mode, prev_inc, prev_dec;
  logic [DW-1:0]   divider, div_inc, div_nxt;
  logic [7:0]      tcnt;
  logic            edge_mode, edge_inc, edge_dec, any_edge;
  logic            div_wrap, timeout, state_chg, do_inc, do_dec;

  function automatic logic [7:0] adj(input logic [7:0] v, input logic [7:0] lim, input logic up);
    if (up) return (v >= lim) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0 || v > lim) ? lim : v - 8'd1;
  endfunction

  assign edge_mode = btn_mode & ~prev_mode;
  assign edge_inc  = btn_inc  & ~prev_inc;
  assign edge_dec  = btn_dec  & ~prev_dec;
  assign any_edge  = edge_mode | edge_inc | edge_dec;

  assign div_wrap = (divider == DW'(TICK_DIV - 1));
  assign div_inc  = div_wrap ? '0 : divider + 1'b1;

  // Timeout fires on the divider wrap that would bring the idle-second count to TIMEOUT_SEC.
  assign timeout = (state != RUN) && !any_edge && div_wrap &&
                   ({1'b0, tcnt} + 9'd1 == 9'(TIMEOUT_SEC));

  always_comb begin
    state_nxt = state;
    if (edge_mode) begin
      case (state)
        RUN:      state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        SET_MIN:  state_nxt = SET_SEC;
        default:  state_nxt = RUN;
      endcase
    end else if (timeout) begin
      state_nxt = RUN;
    end
  end

  assign state_chg = (state_nxt != state);
  assign div_nxt   = state_chg ? '0 : div_inc;
  assign do_inc    = edge_inc & ~edge_dec & ~edge_mode & (state != RUN);
  assign do_dec    = edge_dec & ~edge_inc & ~edge_mode & (state != RUN);
  assign mode      = state;

  always_ff @(posedge clk or negedge _CR) begin
    if (!_CR) begin
      state     <= RUN;
      prev_mode <= 1'b1;
      prev_inc  <= 1'b1;
      prev_dec  <= 1'b1;
      divider   <= '0;
      tcnt      <= 8'd0;
      PE        <= 1'b0;
      blink     <= 1'b0;
      cin_sec   <= 1'b0;
      pre_hour  <= 8'd0;
      pre_min   <= 8'd0;
      pre_sec   <= 8'd0;
    end else begin
      prev_mode <= btn_mode;
      prev_inc  <= btn_inc;
      prev_dec  <= btn_dec;
      state     <= state_nxt;
      divider   <= div_nxt;
      PE        <= (state_nxt != RUN);
      blink     <= (state_nxt != RUN) && (div_nxt < DW'(TICK_DIV / 2));
      // Suppressed when leaving RUN so no carry leaks into a set state.
      cin_sec   <= (state == RUN) && (state_nxt == RUN) && div_wrap;

      if (state_chg || any_edge || state_nxt == RUN) tcnt <= 8'd0;
      else if (div_wrap)                              tcnt <= tcnt + 8'd1;

      if (state == RUN && edge_mode) begin
        pre_hour <= cur_hour;
        pre_min  <= cur_min;
        pre_sec  <= cur_sec;
      end else if (do_inc || do_dec) begin
        case (state)
          SET_HOUR: pre_hour <= adj(pre_hour, 8'd23, do_inc);
          SET_MIN:  pre_min  <= adj(pre_min,  8'd59, do_inc);
          SET_SEC:  pre_sec  <= adj(pre_sec,  8'd59, do_inc);
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Time-setting controller for the digital clock's hour/minute/second counter chain.
- Generates the 1 Hz seconds carry that clocks the chain.
- Sequences a user set mode driven by three buttons: mode, increment, decrement.
- Drives the shared preset bus (pre_hour/pre_min/pre_sec) and the level preset-enable PE consumed by the counters.
- Sits between the debounced button inputs and the counter chain.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per second; must be even and at least 4.
- TIMEOUT_SEC, 10, seconds without a button edge in a set state before automatic return to RUN; range 1..255.

Ports:
- clk  input  1  system clock
- _CR  input  1  asynchronous active-low reset
- btn_mode  input  1  debounced, synchronised level; rising edge advances the mode
- btn_inc  input  1  debounced, synchronised level; rising edge increments the selected field
- btn_dec  input  1  debounced, synchronised level; rising edge decrements the selected field
- cur_hour  input  8  live hour counter value, binary
- cur_min  input  8  live minute counter value, binary
- cur_sec  input  8  live second counter value, binary
- cin_sec  output  1  one-cycle seconds pulse to the counter chain
- pre_hour  output  8  preset hour, binary 0..23
- pre_min  output  8  preset minute, binary 0..59
- pre_sec  output  8  preset second, binary 0..59
- PE  output  1  preset enable, level; high while in any set state
- mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
- blink  output  1  display blink for the selected field

Behaviour:
- Reset (_CR low, asynchronous):
  - state=RUN; mode=0; PE=0; cin_sec=0; blink=0.
  - pre_* = 0; divider=0; timeout counter=0.
  - Button history registers are set to 1, so a button held through reset produces no edge.
- Edge detection: edge_x = btn_x & ~prev_x, with prev_x registered every cycle. Only edges act; held levels are ignored.
- FSM, evaluated on clk rising edge:
  - RUN, mode edge -> SET_HOUR. The same edge captures cur_hour/cur_min/cur_sec into pre_*.
  - SET_HOUR, mode edge -> SET_MIN.
  - SET_MIN, mode edge -> SET_SEC.
  - SET_SEC, mode edge -> RUN.
  - Any set state with timeout counter reaching TIMEOUT_SEC -> RUN.
- Simultaneous edges:
  - mode edge together with inc/dec: mode wins; inc/dec are dropped.
  - inc and dec together: both are dropped.
- Field arithmetic applies to the field selected by state. Limit is 23 for hours and 59 for minutes and seconds.
  - inc: v >= limit -> 0, else v+1.
  - dec: v == 0 or v > limit -> limit, else v-1.
  - Result is visible on pre_* the cycle after the edge.
  - Out-of-range captured values are held unchanged until the first inc/dec on that field.
- PE and mode outputs:
  - PE and mode are registered from the next state, so they change in the same cycle as the state.
  - PE=1 in all set states, 0 in RUN.
  - pre_* remain stable after the return to RUN.
- Divider:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - Cleared to 0 on the cycle any transition into RUN occurs, and on leaving RUN.
- cin_sec = 1 for exactly one cycle when divider == TICK_DIV-1 and state == RUN. It is never asserted in a set state.
  - The first tick after returning to RUN occurs TICK_DIV cycles after PE falls.
- Timeout counter:
  - In set states, increments on divider wrap.
  - Cleared on any inc/dec/mode edge and on every state change.
  - Held at 0 in RUN.
- blink = 1 when in a set state and divider < TICK_DIV/2; else 0 (1 Hz, 50% duty).
- Reset mid-set: immediate return to RUN with pre_* = 0 and PE = 0.

Test Plan:
All scenarios use TICK_DIV=8 and TIMEOUT_SEC=3.
1. Release reset, no buttons, 40 cycles -> cin_sec pulses at cycles 8, 16, 24, 32, 40 after reset release (one cycle each); PE=0, mode=0.
2. cur=12:34:56, mode edge -> next cycle mode=1, PE=1, pre=12/34/56, cin_sec stays 0; inc x12 -> pre_hour=0 (wrap at 23); dec x1 -> 23.
3. Walk SET_HOUR -> SET_MIN -> SET_SEC. In SET_MIN, dec with pre_min=0 -> 59. In SET_SEC, inc with pre_sec=59 -> 0. Next mode edge -> mode=0, PE=0, first cin_sec exactly 8 cycles later.
4. In SET_MIN, inc and dec edges in the same cycle -> pre_min unchanged. Mode and inc edges in the same cycle -> mode=3 and pre_min unchanged.
5. Enter SET_HOUR, no buttons -> return to RUN after 24 cycles (3 divider wraps); blink toggles every 4 cycles before then. An inc edge at cycle 20 restarts the timeout.
6. Hold btn_mode high across reset release -> no mode change. Assert _CR low mid SET_SEC -> outputs immediately at reset values.
